// File: rtl/sram_port_master_if.sv
// ---------------------------------------------------------------------------
// sram_port_master_if
// Purpose : bundles the core-side load/store handshake and the SRAM port-0
//           pins that sram_port_master sits between.
// Signals :
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata
//              core -> master request channel (valid/ready)
//   resp_valid/resp_ready/resp_rdata/resp_err
//              master -> core response channel (valid/ready)
//   csb0/web0/wmask0/addr0/din0/dout0
//              SRAM port 0 (RW) pins, active-low select and write enable
// Modports:
//   master : the port master itself (drives the SRAM pins and the response)
//   slave  : everything around it (requesting core plus the SRAM macro)
// ---------------------------------------------------------------------------
interface sram_port_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_WIDTH+1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  logic                    csb0;
  logic                    web0;
  logic [NUM_WMASKS-1:0]   wmask0;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic [DATA_WIDTH-1:0]   din0;
  logic [DATA_WIDTH-1:0]   dout0;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output csb0, web0, wmask0, addr0, din0,
    input  dout0
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  csb0, web0, wmask0, addr0, din0,
    output dout0
  );

endinterface

// File: rtl/sram_port_master.sv
// ---------------------------------------------------------------------------
// sram_port_master
// Purpose : initiator for port 0 (RW) of the 32x256 byte-masked SRAM macro.
//           Turns one outstanding load/store request into the macro's
//           csb0/web0/wmask0/addr0/din0 timing, captures dout0 and returns an
//           aligned, sign/zero-extended response. Misaligned or illegal-size
//           requests never touch the SRAM and answer with resp_err.
// Ports   :
//   clk    single clock, also clocks the SRAM macro
//   reset  synchronous, active-high
//   bus    sram_port_master_if.master (request, response and SRAM pins)
// Latency (acceptance edge counts as cycle 1):
//   error 1, store 2, load 3; one request in flight at a time.
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ISSUE | SRAM access presented, macro samples it at the next edge
// WAIT  | read in flight, dout0 valid by the next edge
// RESP  | response held until resp_ready
// ---------------------------------------------------------------------------
module sram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_master_if.master bus
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;

  // Request attributes kept for the read-extraction step.
  logic [1:0] size_q;
  logic [1:0] off_q;
  logic       unsigned_q;
  logic       we_q;

  logic [1:0]            req_off;
  logic                  req_illegal;
  logic [DATA_WIDTH-1:0] st_din;
  logic [NUM_WMASKS-1:0] st_wmask;

  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  assign bus.req_ready = (state == IDLE);
  assign req_off       = bus.req_addr[1:0];

  // Request decode and store lane formatting. Store data is replicated across
  // all lanes so the mask alone picks the destination bytes.
  always_comb begin
    req_illegal = 1'b0;
    st_din      = bus.req_wdata;
    st_wmask    = '0;
    case (bus.req_size)
      SIZE_BYTE: begin
        st_din   = {(DATA_WIDTH/8){bus.req_wdata[7:0]}};
        st_wmask = {{(NUM_WMASKS-1){1'b0}}, 1'b1} << req_off;
      end
      SIZE_HALF: begin
        req_illegal = req_off[0];
        st_din      = {(DATA_WIDTH/16){bus.req_wdata[15:0]}};
        st_wmask    = req_off[1] ? {{(NUM_WMASKS/2){1'b1}}, {(NUM_WMASKS/2){1'b0}}}
                                 : {{(NUM_WMASKS/2){1'b0}}, {(NUM_WMASKS/2){1'b1}}};
      end
      SIZE_WORD: begin
        req_illegal = (req_off != 2'b00);
        st_din      = bus.req_wdata;
        st_wmask    = {NUM_WMASKS{1'b1}};
      end
      default: begin
        req_illegal = 1'b1;
      end
    endcase
  end

  // Load extraction from the captured word using the latched offset.
  always_comb begin
    ld_byte = bus.dout0[{off_q, 3'b000} +: 8];
    ld_half = bus.dout0[{off_q[1], 4'b0000} +: 16];
    ld_data = bus.dout0;
    case (size_q)
      SIZE_BYTE: ld_data = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, ld_byte}
                                      : {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, ld_half}
                                      : {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      default:   ld_data = bus.dout0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      unsigned_q     <= 1'b0;
      we_q           <= 1'b0;
      bus.csb0       <= 1'b1;
      bus.web0       <= 1'b1;
      bus.wmask0     <= '0;
      bus.addr0      <= '0;
      bus.din0       <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            size_q     <= bus.req_size;
            off_q      <= req_off;
            unsigned_q <= bus.req_unsigned;
            we_q       <= bus.req_we;
            if (req_illegal) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              state          <= RESP;
            end else begin
              bus.csb0   <= 1'b0;
              bus.web0   <= ~bus.req_we;
              bus.addr0  <= bus.req_addr[ADDR_WIDTH+1:2];
              bus.wmask0 <= bus.req_we ? st_wmask : '0;
              bus.din0   <= st_din;
              state      <= ISSUE;
            end
          end
        end

        // The macro samples the access at this edge; release it immediately.
        // addr0/din0 are left holding their values.
        ISSUE: begin
          bus.csb0   <= 1'b1;
          bus.web0   <= 1'b1;
          bus.wmask0 <= '0;
          if (we_q) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            state          <= RESP;
          end else begin
            state <= WAIT;
          end
        end

        // dout0 settles after the negedge following the sampling edge.
        WAIT: begin
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= ld_data;
          state          <= RESP;
        end

        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_master.sv
module tb_sram_port_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_port_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) bus ();

  sram_port_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM macro model: samples on posedge when selected, read data appears
  // on the following negedge.
  logic [31:0] mem [256];
  logic        rd_pend = 1'b0;
  logic [7:0]  rd_addr = 8'h00;

  always @(posedge clk) begin
    rd_pend <= 1'b0;
    if (!bus.csb0) begin
      if (!bus.web0) begin
        for (int i = 0; i < 4; i++)
          if (bus.wmask0[i]) mem[bus.addr0][8*i +: 8] <= bus.din0[8*i +: 8];
      end else begin
        rd_pend <= 1'b1;
        rd_addr <= bus.addr0;
      end
    end
  end

  always @(negedge clk) if (rd_pend) bus.dout0 <= mem[rd_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: pops an expectation when a new response appears, then checks
  // that it stays stable while stalled.
  logic        active = 1'b0;
  logic [31:0] held_rd;
  logic        held_err;
  string       held_name;

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      check("req_ready_low_in_resp", {31'd0, bus.req_ready}, 32'd0);
      if (!active) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got rdata 0x%08h err %0b, required no response",
                   bus.resp_rdata, bus.resp_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check({e.name, "_rdata"}, bus.resp_rdata, e.rd);
          check({e.name, "_err"}, {31'd0, bus.resp_err}, {31'd0, e.err});
          check({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
          held_name = e.name;
        end
        active   = 1'b1;
        held_rd  = bus.resp_rdata;
        held_err = bus.resp_err;
      end else begin
        check({held_name, "_stable_rdata"}, bus.resp_rdata, held_rd);
        check({held_name, "_stable_err"}, {31'd0, bus.resp_err}, {31'd0, held_err});
      end
    end else begin
      active = 1'b0;
    end
  end

  // Driver: issues one request, checks the SRAM pins on the access cycle,
  // pushes the expected response, and waits for it to be consumed.
  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                       input logic [7:0] exp_addr0, input logic [3:0] exp_wmask,
                       input logic [31:0] exp_din, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.resp_ready   = (hold == 0);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL %s_accept_timeout: req_ready stuck at %0b, required 1", name, bus.req_ready);
    end
    e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat; e.acc = cyc + 1; e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    if (exp_err) begin
      check({name, "_no_access_csb0"}, {31'd0, bus.csb0}, 32'd1);
    end else begin
      check({name, "_csb0"}, {31'd0, bus.csb0}, 32'd0);
      check({name, "_web0"}, {31'd0, bus.web0}, {31'd0, ~we});
      check({name, "_addr0"}, {24'd0, bus.addr0}, {24'd0, exp_addr0});
      check({name, "_wmask0"}, {28'd0, bus.wmask0}, {28'd0, exp_wmask});
      if (we) check({name, "_din0"}, bus.din0, exp_din);
    end
    if (hold > 0) begin
      n = 0;
      while (bus.resp_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      repeat (hold) @(negedge clk);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check({name, "_idle_after_handshake"}, {31'd0, bus.req_ready}, 32'd1);
      check({name, "_valid_dropped"}, {31'd0, bus.resp_valid}, 32'd0);
    end
    n = 0;
    while ((exp_q.size() != 0 || bus.resp_valid === 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL %s_resp_timeout: %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_csb0", {31'd0, bus.csb0}, 32'd1);
    check("rst_web0", {31'd0, bus.web0}, 32'd1);
    check("rst_wmask0", {28'd0, bus.wmask0}, 32'd0);
    check("rst_addr0", {24'd0, bus.addr0}, 32'd0);
    check("rst_din0", bus.din0, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    //     name           we    size  uns   addr    wdata         rdata         err  lat addr0  wmask    din           hold
    issue("st_w0",       1'b1, 2'b10, 1'b0, 10'h000, 32'h01020304, 32'h00000000, 1'b0, 2, 8'h00, 4'b1111, 32'h01020304, 0);
    issue("st_w1_clr",   1'b1, 2'b10, 1'b0, 10'h004, 32'h00000000, 32'h00000000, 1'b0, 2, 8'h01, 4'b1111, 32'h00000000, 0);
    issue("st_w_10",     1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 8'h04, 4'b1111, 32'hDEADBEEF, 0);
    issue("ld_w_10",     1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 8'h04, 4'b0000, 32'h0,        0);
    issue("st_b_05",     1'b1, 2'b00, 1'b0, 10'h005, 32'h000000AB, 32'h00000000, 1'b0, 2, 8'h01, 4'b0010, 32'hABABABAB, 0);
    issue("ld_bs_05",    1'b0, 2'b00, 1'b0, 10'h005, 32'h0,        32'hFFFFFFAB, 1'b0, 3, 8'h01, 4'b0000, 32'h0,        0);
    issue("ld_bu_05",    1'b0, 2'b00, 1'b1, 10'h005, 32'h0,        32'h000000AB, 1'b0, 3, 8'h01, 4'b0000, 32'h0,        0);
    issue("st_b_07",     1'b1, 2'b00, 1'b0, 10'h007, 32'h1234567F, 32'h00000000, 1'b0, 2, 8'h01, 4'b1000, 32'h7F7F7F7F, 0);
    issue("ld_bs_07",    1'b0, 2'b00, 1'b0, 10'h007, 32'h0,        32'h0000007F, 1'b0, 3, 8'h01, 4'b0000, 32'h0,        0);
    issue("ld_w_04",     1'b0, 2'b10, 1'b0, 10'h004, 32'h0,        32'h7F00AB00, 1'b0, 3, 8'h01, 4'b0000, 32'h0,        0);
    issue("ld_hu_06",    1'b0, 2'b01, 1'b1, 10'h006, 32'h0,        32'h00007F00, 1'b0, 3, 8'h01, 4'b0000, 32'h0,        0);
    issue("ld_hs_04",    1'b0, 2'b01, 1'b0, 10'h004, 32'h0,        32'hFFFFAB00, 1'b0, 3, 8'h01, 4'b0000, 32'h0,        0);
    issue("st_w_0c",     1'b1, 2'b10, 1'b0, 10'h00C, 32'h11223344, 32'h00000000, 1'b0, 2, 8'h03, 4'b1111, 32'h11223344, 0);
    issue("st_h_0e",     1'b1, 2'b01, 1'b0, 10'h00E, 32'h00008001, 32'h00000000, 1'b0, 2, 8'h03, 4'b1100, 32'h80018001, 0);
    issue("ld_hs_0e",    1'b0, 2'b01, 1'b0, 10'h00E, 32'h0,        32'hFFFF8001, 1'b0, 3, 8'h03, 4'b0000, 32'h0,        0);
    issue("ld_w_0c",     1'b0, 2'b10, 1'b0, 10'h00C, 32'h0,        32'h80013344, 1'b0, 3, 8'h03, 4'b0000, 32'h0,        0);
    issue("ld_hu_0c",    1'b0, 2'b01, 1'b1, 10'h00C, 32'h0,        32'h00003344, 1'b0, 3, 8'h03, 4'b0000, 32'h0,        0);
    // Errors: no SRAM access, 1-cycle response
    issue("err_ld_w_02", 1'b0, 2'b10, 1'b0, 10'h002, 32'h0,        32'h00000000, 1'b1, 1, 8'h00, 4'b0000, 32'h0,        0);
    issue("err_size11",  1'b0, 2'b11, 1'b0, 10'h000, 32'h0,        32'h00000000, 1'b1, 1, 8'h00, 4'b0000, 32'h0,        0);
    issue("err_ld_h_01", 1'b0, 2'b01, 1'b0, 10'h001, 32'h0,        32'h00000000, 1'b1, 1, 8'h00, 4'b0000, 32'h0,        0);
    issue("err_st_w_03", 1'b1, 2'b10, 1'b0, 10'h003, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 8'h00, 4'b0000, 32'h0,        0);
    issue("err_st_h_0d", 1'b1, 2'b01, 1'b0, 10'h00D, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 8'h00, 4'b0000, 32'h0,        0);
    issue("ld_w_00",     1'b0, 2'b10, 1'b0, 10'h000, 32'h0,        32'h01020304, 1'b0, 3, 8'h00, 4'b0000, 32'h0,        0);
    // Stalled response
    issue("ld_stall",    1'b0, 2'b10, 1'b0, 10'h00C, 32'h0,        32'h80013344, 1'b0, 3, 8'h03, 4'b0000, 32'h0,        3);

    // Reset while in WAIT: no response expected
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_addr   = 10'h010;
    bus.resp_ready = 1'b1;
    check("rw_req_ready_pre", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("rw_csb0", {31'd0, bus.csb0}, 32'd1);
    check("rw_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rw_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rw_no_resp", {31'd0, bus.resp_valid}, 32'd0);

    issue("ld_w_after_rst", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0,     32'hDEADBEEF, 1'b0, 3, 8'h04, 4'b0000, 32'h0,        0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
